pl_mem_arbiter: RTL and testbench
=================================

// Module: pl_mem_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency unified memory between the pipeline's IF stage
//  (instruction fetch) and MEM stage (load/store).
//  Grants one requester at a time and returns read data with a one-cycle ready pulse.
//  Produces the stall terms the pipeline uses to freeze PC/IR and the EX/MEM/WB path.
//  Sits between pl_stage_if / pl_stage_mem and the memory macro in pl_computer.
// PARAMETERS
//  MEM_LAT     2   cycles from mem_en to valid mem_rdata (>=1)
//  STARVE_MAX  4   consecutive data grants with i_req pending before IF is forced a grant (>=1)
// PORTS
//  clk         in   1   system clock, rising edge
//  clrn        in   1   asynchronous active-low reset
//  i_req       in   1   fetch request, held until i_ready
//  i_addr      in   32  fetch address
//  i_rdata     out  32  fetched instruction, valid when i_ready=1
//  i_ready     out  1   one-cycle completion pulse for fetch
//  d_req       in   1   data request, held until d_ready
//  d_we        in   1   1=store, 0=load
//  d_addr      in   32  data address
//  d_wdata     in   32  store data
//  d_rdata     out  32  load data, valid when d_ready=1
//  d_ready     out  1   one-cycle completion pulse for data
//  mem_en      out  1   memory access strobe, one cycle per access
//  mem_we      out  1   memory write enable, qualified by mem_en
//  mem_addr    out  32  memory address
//  mem_wdata   out  32  memory write data
//  mem_rdata   in   32  memory read data, valid MEM_LAT cycles after mem_en
//  stall_if    out  1   i_req & ~i_ready
//  stall_mem   out  1   d_req & ~d_ready
// BEHAVIOUR
//  Reset: clk/clrn async; state=IDLE, all outputs 0, lat counter 0, starve counter 0.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   IDLE: if d_req & ~(i_req & starve==STARVE_MAX) grant D; else if i_req grant I.
//         On grant, latch owner, addr, we (0 for I), wdata; go to ISSUE.
//   ISSUE (1 cycle): mem_en=1, mem_we/addr/wdata = latched values; cnt<=MEM_LAT; go to WAIT.
//   WAIT: cnt decrements each cycle.
//         When cnt==1, register mem_rdata into the owner's rdata (loads/fetches only);
//         go to DONE.
//   DONE (1 cycle): owner's ready=1; go to IDLE.
//  Latency: req sampled in IDLE cycle T -> mem_en in T+1 -> ready in T+2+MEM_LAT.
//  Throughput: one access per MEM_LAT+3 cycles.
//  Priority: data over fetch, since the MEM-stage instruction is older.
//   Starve counter increments on each D grant while i_req=1.
//   It clears on any I grant or when i_req=0.
//   At STARVE_MAX, the next grant goes to I even if d_req=1.
//  Simultaneous i_req & d_req in IDLE follow the priority rule; the loser keeps req high
//   and is served next IDLE.
//  Requests are sampled only in IDLE; changes to a non-owner's inputs during a transaction
//   are ignored.
//  Stores: mem_we=1 in ISSUE; d_ready pulses with the same timing as a load;
//   d_rdata holds its previous value.
//  i_rdata/d_rdata hold their last value until overwritten by that requester's next read.
//  Non-ISSUE cycles: mem_en=0, mem_we=0; mem_addr/mem_wdata hold.
//  Reset mid-operation returns to IDLE immediately: no ready pulse, transaction dropped.
//   A store already strobed in ISSUE may have completed in memory.
//  Requesters must drop or replace req in the cycle after their ready pulse.
//   A req still high in the following IDLE is treated as a new request.
// STRUCTURE
//  pl_mem_pkg: state enum (IDLE, ISSUE, WAIT, DONE), owner encoding (OWN_I, OWN_D),
//   default MEM_LAT / STARVE_MAX constants.
//  Sub-module pl_arb_lat_counter: loadable down-counter with async clear and a cnt==1 flag;
//   width $clog2(MEM_LAT+1).
//  FSM, command latches, starve counter and output registers are in this module.
//  Stall outputs are combinational.
// TESTING
//  1. MEM_LAT=2, i_req=1, i_addr=0x100 in cycle 0, mem returns 0x00500093 ->
//     mem_en=1 with addr 0x100 in cycle 1; i_ready=1, i_rdata=0x00500093 in cycle 4;
//     stall_if=1 in cycles 0-3.
//  2. i_req and d_req (load, 0x2000) both rise in cycle 0 ->
//     D served first (d_ready cycle 4); I issued cycle 6; i_ready cycle 9.
//  3. Store d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF ->
//     mem_en=mem_we=1 with that addr/data for exactly one cycle; d_ready at +4;
//     d_rdata unchanged.
//  4. d_req held high for 6 back-to-back loads, i_req high throughout, STARVE_MAX=4 ->
//     grant order D,D,D,D,I,D,D; no more than 4 consecutive D grants.
//  5. clrn pulsed low during WAIT of a fetch ->
//     outputs 0 immediately; no i_ready; after release a held i_req restarts with
//     mem_en one cycle after the IDLE sample.
//  6. MEM_LAT=1 and MEM_LAT=5 sweeps -> req-to-ready = MEM_LAT+2 cycles;
//     rdata captured from mem_rdata exactly MEM_LAT cycles after mem_en.

Source files
------------

// File: rtl/pl_mem_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM unified-memory arbiter.
package pl_mem_arbiter_pkg;

  localparam int DATA_W         = 32;
  localparam int ADDR_W         = 32;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/pl_mem_arbiter_if.sv
// Fetch port, data port, memory macro port and stall terms of the arbiter.
interface pl_mem_arbiter_if;
  import pl_mem_arbiter_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );

endinterface

// File: rtl/pl_arb_lat_counter.sv
// Loadable down-counter timing the memory read latency; flags the last wait cycle.
module pl_arb_lat_counter #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = $clog2(MEM_LAT + 1)
) (
  input  logic clk,
  input  logic clrn,
  input  logic load,
  input  logic dec,
  output logic is_one
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                   cnt <= '0;
    else if (load)               cnt <= CNT_W'(MEM_LAT);
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/pl_mem_arbiter.sv
// Grants the single-port memory to fetch or data, data first, with a bounded fetch starvation.
module pl_mem_arbiter
  import pl_mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input logic             clk,
  input logic             clrn,
  pl_mem_arbiter_if.slave bus
);

  localparam int STV_W = $clog2(STARVE_MAX + 1);

  state_t            state, state_nx;
  owner_t            owner;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [STV_W-1:0]  starve;
  logic              starve_full;
  logic              grant_i, grant_d;
  logic              cnt_load, cnt_dec, cnt_one, capture;
  logic              mem_en, mem_we, i_ready, d_ready;

  assign starve_full = (starve == STV_W'(STARVE_MAX));

  pl_arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk    (clk),
    .clrn   (clrn),
    .load   (cnt_load),
    .dec    (cnt_dec),
    .is_one (cnt_one)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nx;
  end

  // Data wins unless fetch has already lost STARVE_MAX grants in a row.
  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    capture  = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.d_req && !(bus.i_req && starve_full)) begin
          grant_d  = 1'b1;
          state_nx = ISSUE;
        end else if (bus.i_req) begin
          grant_i  = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        cnt_load = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_one) begin
          capture  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        i_ready  = (owner == OWN_I);
        d_ready  = (owner == OWN_D);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      owner   <= OWN_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant_i || grant_d) begin
      owner  <= grant_d ? OWN_D : OWN_I;
      addr_q <= grant_d ? bus.d_addr : bus.i_addr;
      we_q   <= grant_d & bus.d_we;
      if (grant_d) wdata_q <= bus.d_wdata;
    end
  end

  // Stores leave d_rdata untouched.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (capture) begin
      if (owner == OWN_I) i_rdata_q <= bus.mem_rdata;
      else if (!we_q)     d_rdata_q <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                        starve <= '0;
    else if (!bus.i_req || grant_i)   starve <= '0;
    else if (grant_d && !starve_full) starve <= starve + 1'b1;
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ready   = i_ready;
  assign bus.d_ready   = d_ready;
  assign bus.stall_if  = bus.i_req & ~i_ready;
  assign bus.stall_mem = bus.d_req & ~d_ready;

endmodule

// File: tb/tb_pl_mem_arbiter.sv
// Scoreboard bench for pl_mem_arbiter at MEM_LAT 2 (main), 1 and 5 (latency sweep).
module tb_pl_mem_arbiter;

  localparam int L0 = 2;
  localparam int L1 = 1;
  localparam int L2 = 5;
  localparam logic [31:0] JUNK = 32'hBADC0FFE;

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
  } xact_t;

  logic clk  = 1'b0;
  logic clrn = 1'b1;
  int   cyc  = 0;
  int   n_vec = 0;
  int   n_err = 0;

  xact_t iss_q[3][$];
  xact_t rdy_q[3][$];

  pl_mem_arbiter_if bus0 ();
  pl_mem_arbiter_if bus1 ();
  pl_mem_arbiter_if bus2 ();

  pl_mem_arbiter #(.MEM_LAT(L0), .STARVE_MAX(4)) dut0 (.clk(clk), .clrn(clrn), .bus(bus0));
  pl_mem_arbiter #(.MEM_LAT(L1), .STARVE_MAX(4)) dut1 (.clk(clk), .clrn(clrn), .bus(bus1));
  pl_mem_arbiter #(.MEM_LAT(L2), .STARVE_MAX(4)) dut2 (.clk(clk), .clrn(clrn), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'h00500093 : ((a * 32'h9E3779B1) ^ 32'h13572468);
  endfunction

  // Memory model: data is valid only in the cycle exactly MEM_LAT after mem_en.
  logic [4:0]  v0 = '0, v1 = '0, v2 = '0;
  logic [31:0] a0 [5], a1 [5], a2 [5];
  always @(posedge clk) begin
    v0 <= {v0[3:0], bus0.mem_en};
    v1 <= {v1[3:0], bus1.mem_en};
    v2 <= {v2[3:0], bus2.mem_en};
    a0[0] <= bus0.mem_addr;
    a1[0] <= bus1.mem_addr;
    a2[0] <= bus2.mem_addr;
    for (int k = 1; k < 5; k++) begin
      a0[k] <= a0[k-1];
      a1[k] <= a1[k-1];
      a2[k] <= a2[k-1];
    end
  end
  assign bus0.mem_rdata = v0[L0-1] ? rd(a0[L0-1]) : JUNK;
  assign bus1.mem_rdata = v1[L1-1] ? rd(a1[L1-1]) : JUNK;
  assign bus2.mem_rdata = v2[L2-1] ? rd(a2[L2-1]) : JUNK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void expect_iss(input int g, input int c, input logic [31:0] a,
                                     input logic we, input logic [31:0] d);
    xact_t e;
    e.c = c; e.a = a; e.we = we; e.d = d;
    iss_q[g].push_back(e);
  endfunction

  function automatic void expect_rdy(input int g, input int c, input logic is_d,
                                     input logic [31:0] d);
    xact_t e;
    e.c = c; e.a = '0; e.we = is_d; e.d = d;
    rdy_q[g].push_back(e);
  endfunction

  task automatic mon(input int g, input logic en, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic ir, input logic dr,
                     input logic [31:0] ird, input logic [31:0] drd);
    xact_t e;
    if (en) begin
      if (iss_q[g].size() == 0) check("issue_extra", 32'd1, 32'd0);
      else begin
        e = iss_q[g].pop_front();
        check("issue_cycle", cyc, e.c);
        check("issue_addr", a, e.a);
        check("issue_we", {31'd0, we}, {31'd0, e.we});
        if (e.we) check("issue_wdata", wd, e.d);
      end
    end else begin
      check("we_outside_issue", {31'd0, we}, 32'd0);
    end
    if (ir || dr) begin
      if (rdy_q[g].size() == 0) check("ready_extra", 32'd1, 32'd0);
      else begin
        e = rdy_q[g].pop_front();
        check("ready_cycle", cyc, e.c);
        check("ready_kind", {31'd0, dr}, {31'd0, e.we});
        check("rdata", e.we ? drd : ird, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.mem_en, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata,
        bus0.i_ready, bus0.d_ready, bus0.i_rdata, bus0.d_rdata);
    mon(1, bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata,
        bus1.i_ready, bus1.d_ready, bus1.i_rdata, bus1.d_rdata);
    mon(2, bus2.mem_en, bus2.mem_we, bus2.mem_addr, bus2.mem_wdata,
        bus2.i_ready, bus2.d_ready, bus2.i_rdata, bus2.d_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles on instance 0; stall terms expected high from t0 up to the given ready cycle.
  task automatic run0(input int t0, input int n, input int ri, input int rdc);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (ri >= 0)  check("stall_if",  {31'd0, bus0.stall_if},  {31'd0, (cyc >= t0 && cyc < ri)});
      if (rdc >= 0) check("stall_mem", {31'd0, bus0.stall_mem}, {31'd0, (cyc >= t0 && cyc < rdc)});
      if (bus0.i_ready) bus0.i_req = 1'b0;
      if (bus0.d_ready) bus0.d_req = 1'b0;
    end
  endtask

  initial begin
    int t0, dn, ni;
    logic [31:0] last_d;

    bus0.i_req = 0; bus0.i_addr = 0; bus0.d_req = 0; bus0.d_we = 0; bus0.d_addr = 0; bus0.d_wdata = 0;
    bus1.i_req = 0; bus1.i_addr = 0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = 0; bus1.d_wdata = 0;
    bus2.i_req = 0; bus2.i_addr = 0; bus2.d_req = 0; bus2.d_we = 0; bus2.d_addr = 0; bus2.d_wdata = 0;
    #1 clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_en",   {31'd0, bus0.mem_en},   32'd0);
    check("rst_mem_we",   {31'd0, bus0.mem_we},   32'd0);
    check("rst_mem_addr", bus0.mem_addr,          32'd0);
    check("rst_i_ready",  {31'd0, bus0.i_ready},  32'd0);
    check("rst_d_ready",  {31'd0, bus0.d_ready},  32'd0);
    check("rst_i_rdata",  bus0.i_rdata,           32'd0);
    check("rst_d_rdata",  bus0.d_rdata,           32'd0);
    check("rst_stall_if", {31'd0, bus0.stall_if}, 32'd0);
    @(negedge clk) clrn = 1'b1;
    repeat (2) @(negedge clk);

    // Single fetch
    tick(); t0 = cyc;
    bus0.i_req = 1; bus0.i_addr = 32'h100;
    expect_iss(0, t0 + 1, 32'h100, 1'b0, 32'd0);
    expect_rdy(0, t0 + 4, 1'b0, 32'h00500093);
    run0(t0, 7, t0 + 4, -1);

    // Simultaneous fetch and load: data first
    tick(); t0 = cyc;
    bus0.i_req = 1; bus0.i_addr = 32'h300;
    bus0.d_req = 1; bus0.d_we = 0; bus0.d_addr = 32'h2000;
    expect_iss(0, t0 + 1, 32'h2000, 1'b0, 32'd0);
    expect_rdy(0, t0 + 4, 1'b1, rd(32'h2000));
    expect_iss(0, t0 + 6, 32'h300, 1'b0, 32'd0);
    expect_rdy(0, t0 + 9, 1'b0, rd(32'h300));
    run0(t0, 12, t0 + 9, t0 + 4);
    last_d = rd(32'h2000);

    // Store leaves d_rdata alone
    tick(); t0 = cyc;
    bus0.d_req = 1; bus0.d_we = 1; bus0.d_addr = 32'h2004; bus0.d_wdata = 32'hDEADBEEF;
    expect_iss(0, t0 + 1, 32'h2004, 1'b1, 32'hDEADBEEF);
    expect_rdy(0, t0 + 4, 1'b1, last_d);
    run0(t0, 7, -1, t0 + 4);
    bus0.d_we = 0;

    // Starvation bound: D,D,D,D,I,D,D,I
    tick(); t0 = cyc;
    bus0.i_req = 1; bus0.i_addr = 32'h400;
    bus0.d_req = 1; bus0.d_we = 0; bus0.d_addr = 32'h3000;
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 4 || k == 7) begin
        expect_iss(0, t0 + 1 + 5 * k, 32'h400, 1'b0, 32'd0);
        expect_rdy(0, t0 + 4 + 5 * k, 1'b0, rd(32'h400));
      end else begin
        expect_iss(0, t0 + 1 + 5 * k, 32'h3000 + 4 * dn, 1'b0, 32'd0);
        expect_rdy(0, t0 + 4 + 5 * k, 1'b1, rd(32'h3000 + 4 * dn));
        dn++;
      end
    end
    dn = 0; ni = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (bus0.d_ready) begin
        dn++;
        bus0.d_addr = 32'h3000 + 4 * dn;
        if (dn == 6) bus0.d_req = 1'b0;
      end
      if (bus0.i_ready) begin
        ni++;
        if (ni == 2) bus0.i_req = 1'b0;
      end
    end

    // Reset during WAIT of a fetch, held request restarts
    tick(); t0 = cyc;
    bus0.i_req = 1; bus0.i_addr = 32'h500;
    expect_iss(0, t0 + 1, 32'h500, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    check("midrst_mem_en",   {31'd0, bus0.mem_en},  32'd0);
    check("midrst_i_ready",  {31'd0, bus0.i_ready}, 32'd0);
    check("midrst_i_rdata",  bus0.i_rdata,          32'd0);
    check("midrst_d_rdata",  bus0.d_rdata,          32'd0);
    check("midrst_mem_addr", bus0.mem_addr,         32'd0);
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    expect_iss(0, t0 + 4, 32'h500, 1'b0, 32'd0);
    expect_rdy(0, t0 + 7, 1'b0, rd(32'h500));
    run0(t0 + 3, 8, t0 + 7, -1);

    // Latency sweep: MEM_LAT=1 and MEM_LAT=5, load then fetch on each
    tick(); t0 = cyc;
    bus1.i_req = 1; bus1.i_addr = 32'h600; bus1.d_req = 1; bus1.d_addr = 32'h800;
    bus2.i_req = 1; bus2.i_addr = 32'h700; bus2.d_req = 1; bus2.d_addr = 32'h900;
    expect_iss(1, t0 + 1, 32'h800, 1'b0, 32'd0);
    expect_rdy(1, t0 + 3, 1'b1, rd(32'h800));
    expect_iss(1, t0 + 5, 32'h600, 1'b0, 32'd0);
    expect_rdy(1, t0 + 7, 1'b0, rd(32'h600));
    expect_iss(2, t0 + 1, 32'h900, 1'b0, 32'd0);
    expect_rdy(2, t0 + 7, 1'b1, rd(32'h900));
    expect_iss(2, t0 + 9, 32'h700, 1'b0, 32'd0);
    expect_rdy(2, t0 + 15, 1'b0, rd(32'h700));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus1.i_ready) bus1.i_req = 1'b0;
      if (bus1.d_ready) bus1.d_req = 1'b0;
      if (bus2.i_ready) bus2.i_req = 1'b0;
      if (bus2.d_ready) bus2.d_req = 1'b0;
    end

    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("issue_pending", iss_q[g].size(), 32'd0);
      check("ready_pending", rdy_q[g].size(), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
